// File: rtl/lsq_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsq_issue_scheduler_pkg
//  Description : Shared types for the load/store queue issue scheduler.
//                Provides the scheduler state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsq_issue_scheduler_pkg;

    // NORMAL   : load-priority arbitration with store anti-starvation
    // AMO_LOAD : waiting to issue the read half of an AMO pair
    // AMO_WAIT : read half issued; store waits for every load to return
    // DRAIN    : fence in progress, loads blocked until stores drain
    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        AMO_LOAD = 2'd1,
        AMO_WAIT = 2'd2,
        DRAIN    = 2'd3
    } lsq_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/lsq_issue_scheduler_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lsq_sat_counter
//  Description : Up/down counter saturating at 0 and at MAX_VALUE.
//                Simultaneous inc and dec leave the count unchanged; clr
//                has priority over both.
//  Ports       : clk, rst (sync, active-high), inc, dec, clr, count
//  Revision    : 1.0 - initial release
// ============================================================================
module lsq_sat_counter #(
    parameter int WIDTH     = 3,
    parameter int MAX_VALUE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && !dec && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/lsq_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lsq_issue_scheduler
//  Description : Chooses each cycle whether the load queue head or the store
//                queue head drives the shared sub-unit request path. Loads
//                win by default; a starvation counter forces a store after
//                STARVE_LIMIT consecutive loads. Sequences AMO load/store
//                pairs and drains stores for fences.
//  Ports       : clk, rst            - clock, sync active-high reset
//                lq_valid/lq_subunit  - load head request, lq_pop  - issued
//                sq_valid/sq_subunit  - store head request, sq_pop - issued
//                sq_has_paired_load   - store head is AMO write half
//                sq_empty             - store queue empty
//                unit_ready           - per sub-unit ready
//                unit_issue           - one-hot request strobe
//                issue_is_store       - strobe carries a store
//                load_rsp_valid       - one load response returned
//                fence_req/fence_done - drain request / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module lsq_issue_scheduler
    import lsq_issue_scheduler_pkg::*;
#(
    parameter int NUM_SUBUNITS    = 4,
    parameter int STARVE_LIMIT    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lq_valid,
    input  logic [NUM_SUBUNITS-1:0] lq_subunit,
    output logic                    lq_pop,
    input  logic                    sq_valid,
    input  logic [NUM_SUBUNITS-1:0] sq_subunit,
    input  logic                    sq_has_paired_load,
    input  logic                    sq_empty,
    output logic                    sq_pop,
    input  logic [NUM_SUBUNITS-1:0] unit_ready,
    output logic [NUM_SUBUNITS-1:0] unit_issue,
    output logic                    issue_is_store,
    input  logic                    load_rsp_valid,
    input  logic                    fence_req,
    output logic                    fence_done
);

    localparam int C_OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int C_STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_OUT_W-1:0] C_OUT_MAX = C_OUT_W'(MAX_OUTSTANDING);
    localparam logic [C_STV_W-1:0] C_STV_MAX = C_STV_W'(STARVE_LIMIT);

    lsq_sched_state_t r_state;
    lsq_sched_state_t w_next_state;

    logic [C_OUT_W-1:0] w_outstanding;
    logic [C_STV_W-1:0] w_starve;
    logic               w_ld_ok;
    logic               w_st_ok;
    logic               w_starved;
    logic               w_no_loads;
    logic               w_lq_issue;
    logic               w_sq_issue;
    logic               w_fence_done;

    assign w_ld_ok    = lq_valid && (|(lq_subunit & unit_ready)) && (w_outstanding < C_OUT_MAX);
    assign w_st_ok    = sq_valid && (|(sq_subunit & unit_ready));
    assign w_starved  = (w_starve == C_STV_MAX);
    assign w_no_loads = (w_outstanding == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_lq_issue   = 1'b0;
        w_sq_issue   = 1'b0;
        w_fence_done = 1'b0;
        case (r_state)
            NORMAL: begin
                // An AMO write half is held back so its read half goes first.
                if (w_st_ok && sq_has_paired_load) begin
                    w_next_state = AMO_LOAD;
                end else begin
                    if (w_st_ok && (!w_ld_ok || w_starved)) begin
                        w_sq_issue = 1'b1;
                    end else if (w_ld_ok) begin
                        w_lq_issue = 1'b1;
                    end
                    // A fence only takes effect on an otherwise idle cycle.
                    if (fence_req && !w_sq_issue && !w_lq_issue) begin
                        w_next_state = DRAIN;
                    end
                end
            end
            AMO_LOAD: begin
                if (w_ld_ok) begin
                    w_lq_issue   = 1'b1;
                    w_next_state = AMO_WAIT;
                end
            end
            AMO_WAIT: begin
                if (w_no_loads && w_st_ok) begin
                    w_sq_issue   = 1'b1;
                    w_next_state = NORMAL;
                end
            end
            DRAIN: begin
                w_sq_issue = w_st_ok;
                if (sq_empty && w_no_loads) begin
                    w_fence_done = 1'b1;
                    w_next_state = NORMAL;
                end
            end
            default: begin
                w_next_state = NORMAL;
            end
        endcase
        // Outputs are held quiet for the whole reset window.
        if (rst) begin
            w_lq_issue   = 1'b0;
            w_sq_issue   = 1'b0;
            w_fence_done = 1'b0;
        end
    end

    assign lq_pop         = w_lq_issue;
    assign sq_pop         = w_sq_issue;
    assign issue_is_store = w_sq_issue;
    assign fence_done     = w_fence_done;
    assign unit_issue     = w_lq_issue ? lq_subunit :
                            (w_sq_issue ? sq_subunit : '0);

    lsq_sat_counter #(
        .WIDTH     (C_OUT_W),
        .MAX_VALUE (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_lq_issue),
        .dec   (load_rsp_valid),
        .clr   (1'b0),
        .count (w_outstanding)
    );

    // Counts loads that bypassed an issuable store; reset whenever the store
    // goes out or stops being issuable.
    lsq_sat_counter #(
        .WIDTH     (C_STV_W),
        .MAX_VALUE (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_lq_issue && w_st_ok),
        .dec   (1'b0),
        .clr   (w_sq_issue || !w_st_ok),
        .count (w_starve)
    );

`ifndef SYNTHESIS
    a_single_pop: assert property (@(posedge clk) disable iff (rst)
        !(lq_pop && sq_pop));
    a_issue_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(unit_issue));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(load_rsp_valid && (w_outstanding == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsq_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsq_issue_scheduler
//  Description : Self-checking bench for lsq_issue_scheduler. Directed
//                scenarios plus randomized traffic, all compared against a
//                cycle-level reference model of the scheduling rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsq_issue_scheduler;

    localparam int NSU  = 4;
    localparam int SLIM = 4;
    localparam int MAXO = 4;

    localparam int M_NORMAL = 0;
    localparam int M_AMO_LD = 1;
    localparam int M_AMO_WT = 2;
    localparam int M_DRAIN  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           lq_valid;
    logic [NSU-1:0] lq_subunit;
    logic           lq_pop;
    logic           sq_valid;
    logic [NSU-1:0] sq_subunit;
    logic           sq_has_paired_load;
    logic           sq_empty;
    logic           sq_pop;
    logic [NSU-1:0] unit_ready;
    logic [NSU-1:0] unit_issue;
    logic           issue_is_store;
    logic           load_rsp_valid;
    logic           fence_req;
    logic           fence_done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int         m_mode   = M_NORMAL;
    int         m_next   = M_NORMAL;
    int         m_out    = 0;
    int         m_starve = 0;
    bit         e_lq, e_sq, e_done, e_st_ok;
    logic [3:0] e_issue;
    logic [7:0] e_vec;

    always #5 clk = ~clk;

    lsq_issue_scheduler #(
        .NUM_SUBUNITS    (NSU),
        .STARVE_LIMIT    (SLIM),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lq_valid           (lq_valid),
        .lq_subunit         (lq_subunit),
        .lq_pop             (lq_pop),
        .sq_valid           (sq_valid),
        .sq_subunit         (sq_subunit),
        .sq_has_paired_load (sq_has_paired_load),
        .sq_empty           (sq_empty),
        .sq_pop             (sq_pop),
        .unit_ready         (unit_ready),
        .unit_issue         (unit_issue),
        .issue_is_store     (issue_is_store),
        .load_rsp_valid     (load_rsp_valid),
        .fence_req          (fence_req),
        .fence_done         (fence_done)
    );

    function automatic logic [7:0] obs();
        return {lq_pop, sq_pop, issue_is_store, fence_done, unit_issue};
    endfunction

    // Expected outputs for the current cycle from the current inputs.
    function void model_eval();
        bit ld_ok, st_ok;
        ld_ok = lq_valid && ((lq_subunit & unit_ready) != 0) && (m_out < MAXO);
        st_ok = sq_valid && ((sq_subunit & unit_ready) != 0);
        e_st_ok = st_ok;
        e_lq = 0; e_sq = 0; e_done = 0;
        m_next = m_mode;
        if (m_mode == M_NORMAL) begin
            if (st_ok && sq_has_paired_load) m_next = M_AMO_LD;
            else if (st_ok && (!ld_ok || m_starve == SLIM)) e_sq = 1;
            else if (ld_ok) e_lq = 1;
            if (m_next == M_NORMAL && !e_lq && !e_sq && fence_req) m_next = M_DRAIN;
        end else if (m_mode == M_AMO_LD) begin
            e_lq = ld_ok;
            if (ld_ok) m_next = M_AMO_WT;
        end else if (m_mode == M_AMO_WT) begin
            if (m_out == 0 && st_ok) begin e_sq = 1; m_next = M_NORMAL; end
        end else begin
            e_sq = st_ok;
            if (sq_empty && m_out == 0) begin e_done = 1; m_next = M_NORMAL; end
        end
        if (rst) begin e_lq = 0; e_sq = 0; e_done = 0; end
        e_issue = e_lq ? lq_subunit : (e_sq ? sq_subunit : 4'b0000);
        e_vec   = {e_lq, e_sq, e_sq, e_done, e_issue};
    endfunction

    function void model_update();
        if (rst) begin
            m_mode = M_NORMAL; m_out = 0; m_starve = 0;
        end else begin
            m_out = m_out + (e_lq ? 1 : 0) - ((load_rsp_valid && m_out > 0) ? 1 : 0);
            if (e_sq || !e_st_ok) m_starve = 0;
            else if (e_lq && m_starve < SLIM) m_starve = m_starve + 1;
            m_mode = m_next;
        end
    endfunction

    task tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task set_idle();
        lq_valid = 0; sq_valid = 0; sq_has_paired_load = 0; sq_empty = 1;
        fence_req = 0; load_rsp_valid = 0; unit_ready = 4'b1111;
        lq_subunit = 4'b0001; sq_subunit = 4'b0010;
    endtask

    task test_reset();
        rst = 1; lq_valid = 1; sq_valid = 1; fence_req = 1; unit_ready = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1; model_eval();
            n_checks++;
            if (obs() !== 8'h00) begin
                n_fail++; $display("FAIL reset_outputs cyc %0d: got %b want 00000000", i, obs());
            end
            tick();
        end
        rst = 0; set_idle();
        #1; model_eval();
        n_checks++;
        if (obs() !== e_vec) begin
            n_fail++; $display("FAIL reset_release: got %b want %b", obs(), e_vec);
        end
        tick();
    endtask

    // Bring the model and DUT back to NORMAL with no loads in flight.
    task test_idle_drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (m_mode == M_NORMAL && m_out == 0) break;
            set_idle();
            lq_valid = (m_mode == M_AMO_LD);
            sq_valid = (m_mode == M_AMO_WT);
            sq_empty = !sq_valid;
            load_rsp_valid = (m_out > 0);
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL %s_drain cyc %0d: got %b want %b", name, i, obs(), e_vec);
            end
            tick();
        end
        set_idle();
    endtask

    task test_load_pressure();
        set_idle();
        lq_valid = 1; sq_valid = 1; sq_empty = 0;
        for (int i = 0; i < 15; i++) begin
            load_rsp_valid = (m_out > 0);
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL load_pressure cyc %0d: got %b want %b", i, obs(), e_vec);
            end
            n_checks++;
            if ({lq_pop, sq_pop} !== {(i % 5) != 4, (i % 5) == 4}) begin
                n_fail++; $display("FAIL load_pressure_pattern cyc %0d: lq/sq %b%b", i, lq_pop, sq_pop);
            end
            tick();
        end
        test_idle_drain("load_pressure");
    endtask

    task test_outstanding_cap();
        set_idle();
        lq_valid = 1;
        for (int i = 0; i < 9; i++) begin
            load_rsp_valid = (i == 6);
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL out_cap cyc %0d: got %b want %b", i, obs(), e_vec);
            end
            n_checks++;
            if (lq_pop !== ((i < 4) || (i == 7))) begin
                n_fail++; $display("FAIL out_cap_pop cyc %0d: lq_pop %b", i, lq_pop);
            end
            tick();
        end
        test_idle_drain("out_cap");
    endtask

    task test_amo();
        bit exp_l [8] = '{1, 0, 1, 0, 0, 0, 0, 1};
        bit exp_s [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        set_idle();
        for (int i = 0; i < 8; i++) begin
            lq_valid = (i != 1);
            sq_valid = (i >= 1 && i <= 6);
            sq_empty = !sq_valid;
            sq_has_paired_load = sq_valid;
            sq_subunit = 4'b0100;
            lq_subunit = 4'b0010;
            load_rsp_valid = (i == 4 || i == 5);
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL amo cyc %0d: got %b want %b", i, obs(), e_vec);
            end
            n_checks++;
            if ({lq_pop, sq_pop} !== {exp_l[i], exp_s[i]}) begin
                n_fail++; $display("FAIL amo_seq cyc %0d: lq/sq %b%b want %b%b", i, lq_pop, sq_pop, exp_l[i], exp_s[i]);
            end
            tick();
        end
        test_idle_drain("amo");
    endtask

    task test_fence();
        bit exp_l [6] = '{0, 0, 0, 0, 0, 1};
        bit exp_s [6] = '{0, 1, 1, 1, 0, 0};
        bit exp_d [6] = '{0, 0, 0, 0, 1, 0};
        int remaining = 3;
        set_idle();
        for (int i = 0; i < 6; i++) begin
            fence_req  = (i == 0);
            unit_ready = (i == 0) ? 4'b0000 : 4'b1111;
            lq_valid   = 1;
            sq_valid   = (remaining > 0);
            sq_empty   = (remaining == 0);
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL fence cyc %0d: got %b want %b", i, obs(), e_vec);
            end
            n_checks++;
            if ({lq_pop, sq_pop, fence_done} !== {exp_l[i], exp_s[i], exp_d[i]}) begin
                n_fail++; $display("FAIL fence_seq cyc %0d: lq/sq/done %b%b%b want %b%b%b",
                                   i, lq_pop, sq_pop, fence_done, exp_l[i], exp_s[i], exp_d[i]);
            end
            if (i >= 1 && remaining > 0) remaining--;
            tick();
        end
        test_idle_drain("fence");
    endtask

    task test_unit_busy();
        set_idle();
        lq_valid = 1; sq_valid = 1; sq_empty = 0;
        lq_subunit = 4'b0010; sq_subunit = 4'b0001; unit_ready = 4'b0001;
        #1; model_eval();
        n_checks++;
        if ({unit_issue, issue_is_store, sq_pop, lq_pop} !== {4'b0001, 1'b1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL unit_busy: issue %b store %b want 0001 1", unit_issue, issue_is_store);
        end
        tick();
        unit_ready = 4'b0010;
        #1; model_eval();
        n_checks++;
        if (obs() !== e_vec) begin
            n_fail++; $display("FAIL unit_busy_load: got %b want %b", obs(), e_vec);
        end
        tick();
        test_idle_drain("unit_busy");
    endtask

    task test_reset_mid_amo();
        set_idle();
        for (int i = 0; i < 11; i++) begin
            rst = (i == 3 || i == 4);
            lq_valid = (i != 1);
            sq_valid = (i >= 1 && i <= 4);
            sq_empty = !sq_valid;
            sq_has_paired_load = sq_valid;
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL rst_amo cyc %0d: got %b want %b", i, obs(), e_vec);
            end
            if (rst) begin
                n_checks++;
                if (obs() !== 8'h00) begin
                    n_fail++; $display("FAIL rst_amo_quiet cyc %0d: got %b want 00000000", i, obs());
                end
            end
            if (i >= 5) begin
                n_checks++;
                if (lq_pop !== (i < 9)) begin
                    n_fail++; $display("FAIL rst_amo_cleared cyc %0d: lq_pop %b want %b", i, lq_pop, i < 9);
                end
            end
            tick();
        end
        rst = 0;
        test_idle_drain("rst_amo");
    endtask

    task test_random();
        for (int i = 0; i < 600; i++) begin
            rst                = ($urandom % 100) == 0;
            lq_valid           = ($urandom % 3) != 0;
            sq_valid           = ($urandom % 2) == 1;
            sq_empty           = !sq_valid && (($urandom % 2) == 1);
            sq_has_paired_load = ($urandom % 8) == 0;
            fence_req          = ($urandom % 10) == 0;
            lq_subunit         = 4'(1 << ($urandom % 4));
            sq_subunit         = 4'(1 << ($urandom % 4));
            unit_ready         = 4'($urandom);
            load_rsp_valid     = (m_out > 0) && (($urandom % 3) == 0);
            #1; model_eval();
            n_checks++;
            if (obs() !== e_vec) begin
                n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs(), e_vec);
            end
            tick();
        end
        rst = 0;
        test_idle_drain("random");
    endtask

    initial begin
        rst = 1;
        set_idle();
        @(negedge clk);
        test_reset();
        test_load_pressure();
        test_outstanding_cap();
        test_amo();
        test_fence();
        test_unit_busy();
        test_reset_mid_amo();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
